// File: rtl/snow64_mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter: FSM state, requester ids and port-group structs.
// The priority override macro SNOW64_MEM_ARB_DCACHE_PRIO_EN is consumed by snow64_mem_arb_picker.
package PkgSnow64MemArbiter;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 256;

    typedef enum logic [0:0] {
        StIdle       = 1'b0,
        StWaitForMem = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        ReqICache = 1'b0,
        ReqDCache = 1'b1
    } requester_t;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
    } icache_req_t;

    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] data;
    } icache_resp_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } dcache_req_t;

    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] rdata;
    } dcache_resp_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } mem_access_out_t;

    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] rdata;
    } mem_access_in_t;

endpackage

// File: rtl/snow64_mem_arb_picker.sv
// Combinational winner selection between the icache and dcache candidates.
// Round-robin by default; SNOW64_MEM_ARB_DCACHE_PRIO_EN makes dcache win every tie.
module snow64_mem_arb_picker
    import PkgSnow64MemArbiter::*;
(
    input  logic       cand_icache,
    input  logic       cand_dcache,
    input  requester_t last_served,
    output logic       grant_valid,
    output requester_t grant
);

`ifdef SNOW64_MEM_ARB_DCACHE_PRIO_EN
    // History is still kept by the top but has no effect on the choice here.
    logic unused_last_served;
    assign unused_last_served = last_served[0];
`endif

    always_comb begin
        grant_valid = cand_icache | cand_dcache;
        grant       = ReqICache;
        if (cand_icache && cand_dcache) begin
`ifdef SNOW64_MEM_ARB_DCACHE_PRIO_EN
            grant = ReqDCache;
`else
            grant = (last_served == ReqDCache) ? ReqICache : ReqDCache;
`endif
        end else if (cand_dcache) begin
            grant = ReqDCache;
        end
    end

endmodule

// File: rtl/snow64_mem_access_arbiter.sv
// Shares one memory line port between icache fills and dcache reads/write-backs, one transaction at a time.
// Tie policy selected by SNOW64_MEM_ARB_DCACHE_PRIO_EN (see snow64_mem_arb_picker).
module snow64_mem_access_arbiter
    import PkgSnow64MemArbiter::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int LINE_WIDTH = LINE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_icache_req,
    input  logic [ADDR_WIDTH-1:0] in_icache_addr,
    output logic                  out_icache_valid,
    output logic [LINE_WIDTH-1:0] out_icache_data,
    input  logic                  in_dcache_req,
    input  logic                  in_dcache_we,
    input  logic [ADDR_WIDTH-1:0] in_dcache_addr,
    input  logic [LINE_WIDTH-1:0] in_dcache_wdata,
    output logic                  out_dcache_valid,
    output logic [LINE_WIDTH-1:0] out_dcache_rdata,
    output logic                  out_mem_req,
    output logic                  out_mem_we,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [LINE_WIDTH-1:0] out_mem_wdata,
    input  logic                  in_mem_valid,
    input  logic [LINE_WIDTH-1:0] in_mem_rdata,
    output logic                  out_busy
);

    // Handshake: every req/valid here is a single-cycle pulse with no ready; a req
    // that cannot be held (slot full or its own transaction in flight) is dropped.
    state_t          state;
    requester_t      grant;
    requester_t      last_served;
    requester_t      winner;
    icache_req_t     i_slot;
    dcache_req_t     d_slot;
    mem_access_out_t mem_q;
    icache_resp_t    i_resp_q;
    dcache_resp_t    d_resp_q;

    logic                  in_flight_i, in_flight_d;
    logic                  fill_i, fill_d;
    logic                  cand_i, cand_d;
    logic                  pick_valid;
    logic [ADDR_WIDTH-1:0] sel_i_addr, sel_d_addr;
    logic                  sel_d_we;
    logic [LINE_WIDTH-1:0] sel_d_wdata;

    assign in_flight_i = (state == StWaitForMem) && (grant == ReqICache);
    assign in_flight_d = (state == StWaitForMem) && (grant == ReqDCache);
    assign fill_i      = in_icache_req && !i_slot.req && !in_flight_i;
    assign fill_d      = in_dcache_req && !d_slot.req && !in_flight_d;

    // Same-cycle pulses bypass the slot so an idle arbiter issues on the next edge.
    assign cand_i      = (state == StIdle) && (i_slot.req || in_icache_req);
    assign cand_d      = (state == StIdle) && (d_slot.req || in_dcache_req);
    assign sel_i_addr  = i_slot.req ? i_slot.addr  : in_icache_addr;
    assign sel_d_addr  = d_slot.req ? d_slot.addr  : in_dcache_addr;
    assign sel_d_we    = d_slot.req ? d_slot.we    : in_dcache_we;
    assign sel_d_wdata = d_slot.req ? d_slot.wdata : in_dcache_wdata;

    snow64_mem_arb_picker u_picker (
        .cand_icache (cand_i),
        .cand_dcache (cand_d),
        .last_served (last_served),
        .grant_valid (pick_valid),
        .grant       (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            grant       <= ReqICache;
            last_served <= ReqDCache;
            i_slot      <= '0;
            d_slot      <= '0;
            mem_q       <= '0;
            i_resp_q    <= '0;
            d_resp_q    <= '0;
        end else begin
            mem_q.req      <= 1'b0;
            i_resp_q.valid <= 1'b0;
            d_resp_q.valid <= 1'b0;

            if (fill_i) begin
                i_slot.req  <= 1'b1;
                i_slot.addr <= in_icache_addr;
            end
            if (fill_d) begin
                d_slot.req   <= 1'b1;
                d_slot.we    <= in_dcache_we;
                d_slot.addr  <= in_dcache_addr;
                d_slot.wdata <= in_dcache_wdata;
            end

            if (state == StIdle) begin
                if (pick_valid) begin
                    mem_q.req <= 1'b1;
                    grant     <= winner;
                    state     <= StWaitForMem;
                    if (winner == ReqICache) begin
                        mem_q.we    <= 1'b0;
                        mem_q.addr  <= sel_i_addr;
                        mem_q.wdata <= '0;
                        i_slot.req  <= 1'b0;
                    end else begin
                        mem_q.we    <= sel_d_we;
                        mem_q.addr  <= sel_d_addr;
                        mem_q.wdata <= sel_d_wdata;
                        d_slot.req  <= 1'b0;
                    end
                end
            end else if (in_mem_valid) begin
                if (grant == ReqICache) begin
                    i_resp_q.valid <= 1'b1;
                    i_resp_q.data  <= in_mem_rdata;
                end else begin
                    d_resp_q.valid <= 1'b1;
                    if (!mem_q.we) begin
                        d_resp_q.rdata <= in_mem_rdata;
                    end
                end
                last_served <= grant;
                state       <= StIdle;
            end
        end
    end

    assign out_mem_req      = mem_q.req;
    assign out_mem_we       = mem_q.we;
    assign out_mem_addr     = mem_q.addr;
    assign out_mem_wdata    = mem_q.wdata;
    assign out_icache_valid = i_resp_q.valid;
    assign out_icache_data  = i_resp_q.data;
    assign out_dcache_valid = d_resp_q.valid;
    assign out_dcache_rdata = d_resp_q.rdata;
    assign out_busy         = (state == StWaitForMem);

endmodule
